// File: rtl/sound_pkg.sv
// Shared definitions for the sound path: FSM states, default parameters and a
// saturating absolute-value helper.
package sound_pkg;

    typedef enum logic [2:0] {StIdle, StAbs, StEnv, StGain, StDone} state_e;

    localparam int unsigned DefWidth     = 16;
    localparam int unsigned DefChannels  = 2;
    localparam int unsigned DefAttackSh  = 4;
    localparam int unsigned DefReleaseSh = 10;
    localparam int unsigned DefRatioSh   = 2;

    // |x| for a w-bit signed value held sign-extended in 32 bits; the most
    // negative code saturates to the largest positive magnitude.
    function automatic logic [31:0] sat_abs(input logic signed [31:0] x, input int unsigned w);
        logic signed [31:0] most_neg;
        most_neg = -(32'sd1 <<< (w - 1));
        if (x == most_neg) return (32'd1 << (w - 1)) - 32'd1;
        if (x < 0) return $unsigned(-x);
        return $unsigned(x);
    endfunction

endpackage

// File: rtl/dyn_comp_gain.sv
// Combinational gain stage: applies the power-of-two ratio above threshold and
// restores the sign of the original sample.
module dyn_comp_gain import sound_pkg::*; #(
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned RATIO_SH = DefRatioSh
) (
    input  logic        [WIDTH-2:0] m,
    input  logic                    sign,
    input  logic        [WIDTH-2:0] env,
    input  logic        [WIDTH-2:0] threshold,
    input  logic                    bypass,
    input  logic signed [WIDTH-1:0] x,
    output logic signed [WIDTH-1:0] y
);

    logic [WIDTH-2:0] e;
    logic [WIDTH-2:0] r;
    logic [WIDTH-2:0] mag;

    always_comb begin
        e   = '0;
        r   = '0;
        mag = '0;
        y   = x;
        if (!bypass && (env > threshold)) begin
            e   = env - threshold;
            r   = e - (e >> RATIO_SH);
            mag = (m > r) ? (m - r) : '0;
            y   = sign ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
        end
    end

endmodule

// File: rtl/dyn_compressor.sv
// Multi-channel dynamic-range compressor; channels share one ABS/ENV/GAIN datapath
// sequenced by a small FSM, one frame in and one frame out per strobe.
module dyn_compressor import sound_pkg::*; #(
    parameter int unsigned WIDTH      = DefWidth,
    parameter int unsigned CHANNELS   = DefChannels,
    parameter int unsigned ATTACK_SH  = DefAttackSh,
    parameter int unsigned RELEASE_SH = DefReleaseSh,
    parameter int unsigned RATIO_SH   = DefRatioSh
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [WIDTH-2:0]          threshold,
    input  logic                      bypass,
    output logic                      out_valid,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      busy,
    output logic                      drop
);

    localparam int unsigned CntW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CntW-1:0] LastCh = CntW'(CHANNELS - 1);

    state_e                  state_q, state_d;
    logic [CntW-1:0]         ch_q, ch_d;
    logic signed [WIDTH-1:0] in_q  [CHANNELS];
    logic signed [WIDTH-1:0] acc_q [CHANNELS];
    logic [WIDTH-2:0]        env_q [CHANNELS];
    logic [WIDTH-2:0]        thr_q;
    logic                    byp_q;
    logic [WIDTH-2:0]        m_q;
    logic [CHANNELS*WIDTH-1:0] out_q;
    logic                    out_valid_q;
    logic                    drop_q;

    logic                    accept;
    logic signed [WIDTH-1:0] x_cur;
    logic [WIDTH-2:0]        m_abs;
    logic [WIDTH-2:0]        env_cur, env_new, diff, step;
    logic                    rise;
    logic signed [WIDTH-1:0] y_gain;

    assign busy   = (state_q != StIdle);
    assign accept = in_valid && !busy;
    assign x_cur  = in_q[ch_q];
    assign m_abs  = (WIDTH-1)'(sat_abs(32'(x_cur), WIDTH));
    assign env_cur = env_q[ch_q];

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StAbs;
                    ch_d    = '0;
                end
            end
            StAbs:  state_d = StEnv;
            StEnv:  state_d = StGain;
            StGain: begin
                if (ch_q == LastCh) begin
                    state_d = StDone;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = StAbs;
                end
            end
            StDone: begin
                state_d = StIdle;
                ch_d    = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    // Envelope follower; the minimum step of 1 guarantees convergence onto m.
    always_comb begin
        rise    = (m_q > env_cur);
        diff    = rise ? (m_q - env_cur) : (env_cur - m_q);
        step    = rise ? (diff >> ATTACK_SH) : (diff >> RELEASE_SH);
        if ((diff != '0) && (step == '0)) step = (WIDTH-1)'(1);
        env_new = rise ? (env_cur + step) : (env_cur - step);
    end

    dyn_comp_gain #(
        .WIDTH    (WIDTH),
        .RATIO_SH (RATIO_SH)
    ) u_gain (
        .m         (m_q),
        .sign      (x_cur[WIDTH-1]),
        .env       (env_cur),
        .threshold (thr_q),
        .bypass    (byp_q),
        .x         (x_cur),
        .y         (y_gain)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            ch_q        <= '0;
            thr_q       <= '0;
            byp_q       <= 1'b0;
            m_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            drop_q      <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                in_q[c]  <= '0;
                acc_q[c] <= '0;
                env_q[c] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            out_valid_q <= (state_q == StDone);
            drop_q      <= in_valid && busy;
            if (accept) begin
                thr_q <= threshold;
                byp_q <= bypass;
                for (int c = 0; c < CHANNELS; c++) in_q[c] <= in_data[c*WIDTH +: WIDTH];
            end
            if (state_q == StAbs)  m_q          <= m_abs;
            if (state_q == StEnv)  env_q[ch_q]  <= env_new;
            if (state_q == StGain) acc_q[ch_q]  <= y_gain;
            if (state_q == StDone) begin
                for (int c = 0; c < CHANNELS; c++) out_q[c*WIDTH +: WIDTH] <= acc_q[c];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_dyn_compressor.sv
// Directed bench for dyn_compressor with default parameters and threshold 8192.
module tb_dyn_compressor;

    localparam int W  = 16;
    localparam int CH = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [CH*W-1:0]   in_data;
    logic [W-2:0]      threshold;
    logic              bypass;
    logic              out_valid;
    logic [CH*W-1:0]   out_data;
    logic              busy;
    logic              drop;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dyn_compressor dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .threshold (threshold),
        .bypass    (bypass),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .drop      (drop)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input longint e0, input longint e1);
        check({tag, "_ch0"}, longint'($signed(out_data[15:0])), e0);
        check({tag, "_ch1"}, longint'($signed(out_data[31:16])), e1);
    endtask

    task automatic check_env(input string tag, input longint e0, input longint e1);
        check({tag, "_env0"}, longint'(dut.env_q[0]), e0);
        check({tag, "_env1"}, longint'(dut.env_q[1]), e1);
    endtask

    // Entered #1 after a posedge; returns edges from accept to out_valid (20 = timeout).
    task automatic run_frame(input logic signed [15:0] x0, input logic signed [15:0] x1,
                             input logic byp, output int lat);
        in_data  = {x1, x0};
        bypass   = byp;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1 lat++;
            if (out_valid) break;
        end
    endtask

    initial begin
        int lat;
        int n;
        bit seen;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        bypass    = 1'b0;
        threshold = 15'd8192;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_drop", longint'(drop), 0);
        check("rst_out_data", longint'(out_data), 0);
        reset = 1'b0;

        run_frame(16'sd1600, 16'sd1600, 1'b0, lat);
        check("first_lat", lat, 7);
        check_out("first", 1600, 1600);
        check_env("first", 100, 100);

        for (int i = 0; i < 50; i++) begin
            run_frame(16'sd4000, -16'sd4000, 1'b0, lat);
            check("below_lat", lat, 7);
            check_out("below", 4000, -4000);
        end

        n = 0;
        while (!(dut.env_q[0] == 15'd16384 && dut.env_q[1] == 15'd16384) && n < 400) begin
            run_frame(16'sd16384, -16'sd16384, 1'b0, lat);
            n++;
        end
        check_env("converge", 16384, 16384);
        run_frame(16'sd16384, -16'sd16384, 1'b0, lat);
        check("steady_lat", lat, 7);
        check_out("steady", 10240, -10240);

        // Most negative code: magnitude saturates to 32767 when compressed.
        run_frame(-16'sd32768, -16'sd16384, 1'b0, lat);
        check_out("minneg", -25855, -10240);
        check_env("minneg", 17407, 16384);
        run_frame(-16'sd32768, -16'sd16384, 1'b1, lat);
        check_out("minneg_byp", -32768, -16384);
        check_env("minneg_byp", 18367, 16384);

        run_frame(16'sd0, 16'sd0, 1'b0, lat);
        check_out("release1", 0, 0);
        check_env("release1", 18350, 16368);
        run_frame(16'sd0, 16'sd0, 1'b0, lat);
        check_out("release2", 0, 0);
        check_env("release2", 18333, 16353);

        // Frame strobe while busy must be dropped without disturbing the frame.
        in_data  = '0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b1;
        in_data = {16'sd1000, 16'sd1000};
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("drop_pulse", longint'(drop), 1);
        check("drop_busy", longint'(busy), 1);
        lat = 2;
        while (lat < 20) begin
            @(posedge clk);
            #1 lat++;
            if (out_valid) break;
        end
        check("drop_lat", lat, 7);
        check_out("drop", 0, 0);
        check_env("drop", 18316, 16338);
        @(posedge clk);
        #1;
        check("drop_after_valid", longint'(out_valid), 0);
        check("drop_after_busy", longint'(busy), 0);
        check("drop_after_drop", longint'(drop), 0);

        // Reset sampled at edge 3 of a frame.
        in_data  = {16'sd1600, 16'sd1600};
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check_env("midrst", 0, 0);
        check("midrst_busy", longint'(busy), 0);
        check("midrst_out_data", longint'(out_data), 0);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1 if (out_valid) seen = 1'b1;
        end
        check("midrst_no_valid", longint'(seen), 0);

        // Reset wins over a simultaneous frame strobe.
        reset    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        in_valid = 1'b0;
        check("rst_vs_valid_busy", longint'(busy), 0);

        run_frame(16'sd1600, 16'sd1600, 1'b0, lat);
        check("post_rst_lat", lat, 7);
        check_out("post_rst", 1600, 1600);
        check_env("post_rst", 100, 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dyn_compressor.md
# dyn_compressor

Parametrised multi-channel dynamic-range compressor for the sound path. It replaces the fixed, memoryless two-slope curve with a per-channel envelope follower (separate attack and release), a runtime threshold, a power-of-two ratio and a bypass mode. Channels are processed time-multiplexed through one shared datapath. The block sits between the sound mixer output and the DAC/I2S serialiser and exchanges one frame (all channels) per `in_valid`/`out_valid` pulse.

## Interface
Parameters:
- `WIDTH`, 16: sample width, signed two's complement.
- `CHANNELS`, 2: number of channels per frame (≥1).
- `ATTACK_SH`, 4: attack coefficient, env moves 1/2^ATTACK_SH of the difference per frame.
- `RELEASE_SH`, 10: release coefficient, same rule.
- `RATIO_SH`, 2: compression ratio 2^RATIO_SH : 1 above threshold.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: frame strobe, one cycle.
- `in_data` in CHANNELS*WIDTH: channel c at bits [c*WIDTH +: WIDTH].
- `threshold` in WIDTH-1: unsigned magnitude threshold, sampled at accept.
- `bypass` in 1: sampled at accept; output = input, envelope still updated.
- `out_valid` out 1: one-cycle pulse, frame result ready.
- `out_data` out CHANNELS*WIDTH: same packing, held until next `out_valid`.
- `busy` out 1: frame in progress, `in_valid` not accepted.
- `drop` out 1: one-cycle pulse when `in_valid` arrives while `busy`.

## Operation
- Reset values: `out_valid`=0, `out_data`=0, `busy`=0, `drop`=0, all envelopes=0, FSM=IDLE, channel counter=0.
- Accept: `in_valid`=1 and `busy`=0. Latches `in_data`, `threshold`, `bypass`. Enters ABS with channel 0. `busy` goes high.
- `in_valid` while `busy`=1: frame discarded, `drop`=1 next cycle, state unaffected.
- FSM: IDLE → ABS → ENV → GAIN → (next channel: ABS | last channel: DONE) → IDLE.
- DONE: writes the assembled `out_data`, pulses `out_valid` and clears `busy`.
- ABS stage:
  - m = |x|, WIDTH-1 bits unsigned.
  - x = -2^(WIDTH-1) saturates to 2^(WIDTH-1)-1.
- ENV stage, with d = |m - env| and step = d >> SH, where SH = ATTACK_SH if m > env, else RELEASE_SH:
  - If d ≠ 0 and step = 0, then step = 1, so the envelope always converges.
  - env moves toward m by step and never overshoots m.
- GAIN stage:
  - If bypass, y = x exactly, with no saturation.
  - Else if env ≤ threshold, y = x.
  - Else e = env - threshold, r = e - (e >> RATIO_SH), and |y| = max(0, m - r).
  - y takes the sign of x. A zero magnitude gives y = 0.
- All intermediate values are WIDTH-1 bits unsigned, with no wrap. Subtractions that would go negative clamp to 0.

## Timing
- Accept at clock edge 0. Each channel takes 3 cycles (ABS, ENV, GAIN), then 1 DONE cycle.
- `out_valid` is high in the cycle after edge 3*CHANNELS+1. With CHANNELS=2 that is 7 edges.
- `busy` is low in the `out_valid` cycle, so a new frame may be accepted in that same cycle: back-to-back throughput is one frame per 3*CHANNELS+1 clocks.
- `threshold`/`bypass` changes after accept take effect from the next frame.
- `reset` mid-frame: at the next edge all outputs and envelopes return to reset values and the partial frame is lost (no `out_valid`).
- `reset` together with `in_valid`: reset wins, the frame is not accepted.

## Structure
- Shared package `sound_pkg`:
  - FSM state enum (IDLE, ABS, ENV, GAIN, DONE).
  - Default parameter constants.
  - Saturating-abs helper function.
- One combinational sub-module, `dyn_comp_gain`: inputs m, sign, env, threshold, bypass, raw x; output y. The top holds the FSM, channel counter, envelope register array (CHANNELS × WIDTH-1) and input/output frame registers.

## Test plan
Defaults: WIDTH=16, CHANNELS=2, ATTACK_SH=4, RELEASE_SH=10, RATIO_SH=2, threshold=8192.

- Reset: assert `reset` 2 cycles → `out_valid`=0, `busy`=0, `drop`=0, `out_data`=0. First frame of 1600/1600 → env 100 on both channels, output 1600/1600.
- Below threshold: 4000 / -4000 for 50 frames → output 4000 / -4000 every frame, `out_valid` exactly 7 edges after each accept.
- Steady compression: 16384 / -16384 until env = 16384 (check convergence) → e=8192, r=6144, output 10240 / -10240.
- Extremes: -32768 with bypass=0 → magnitude treated as 32767, sign negative. Same with bypass=1 → output exactly -32768, envelope still updated.
- Release then drop:
  - After env=16384, feed 0 frames → env falls by max(1, env>>10) per frame, with output 0.
  - `in_valid` during `busy` → `drop` pulse, result unchanged.
- Reset mid-frame: assert `reset` at edge 3 of a frame → no `out_valid`, envelopes 0. The next frame behaves as the first after reset.
